// File: rtl/morse_char_assembler.sv
// Morse character assembler: folds dot/dash/gap pulses from the element decoder into
// {len, pattern} character records and queues them in a show-ahead FIFO for a consumer.
module morse_char_assembler #(
    parameter int unsigned MAX_ELEMS = 5,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CW        = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dot,
    input  logic          dash,
    input  logic          lg,
    input  logic          wg,
    input  logic          flush,
    output logic [7:0]    out_code,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] fifo_count,
    output logic          dropped
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0]    MaxLen    = 3'(MAX_ELEMS);
    localparam logic [2:0]    SatLen    = 3'd7;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);
    localparam logic [7:0]    SpaceRec  = 8'h00;
    localparam logic [7:0]    ErrorRec  = 8'hE0;

    localparam logic [0:0] StCollect   = 1'b0;
    localparam logic [0:0] StPushSpace = 1'b1;

    // ------------------------------------------------------------------
    // Character accumulator and sequencing FSM
    // ------------------------------------------------------------------
    logic [0:0] state_q, state_d;
    logic [2:0] len_q, len_d;
    logic [4:0] pattern_q, pattern_d;

    logic       elem;
    logic       clear;
    logic [2:0] len_base;
    logic [4:0] pattern_base;
    logic [7:0] char_rec;
    logic       push;
    logic [7:0] push_rec;

    always_comb begin
        elem     = dot | dash;
        // Once len passes MAX_ELEMS the character is unrecoverable; report it as an error.
        char_rec = (len_q > MaxLen) ? ErrorRec : {len_q, pattern_q};

        state_d  = StCollect;
        clear    = 1'b0;
        push     = 1'b0;
        push_rec = SpaceRec;

        if (state_q == StPushSpace) begin
            push     = 1'b1;
            push_rec = SpaceRec;
        end else if (wg) begin
            push  = 1'b1;
            clear = 1'b1;
            if (len_q != 3'd0) begin
                push_rec = char_rec;
                state_d  = StPushSpace;
            end
        end else if (lg | flush) begin
            clear = 1'b1;
            if (len_q != 3'd0) begin
                push     = 1'b1;
                push_rec = char_rec;
            end
        end

        // A same-cycle element lands in the freshly cleared accumulator.
        len_base     = clear ? 3'd0 : len_q;
        pattern_base = clear ? 5'd0 : pattern_q;

        if (elem) begin
            pattern_d = {pattern_base[3:0], dash};
            len_d     = (len_base == SatLen) ? SatLen : len_base + 3'd1;
        end else begin
            pattern_d = pattern_base;
            len_d     = len_base;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StCollect;
            len_q     <= 3'd0;
            pattern_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            pattern_q <= pattern_d;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead record FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          dropped_q, dropped_d;

    logic full;
    logic pop;
    logic push_ok;

    always_comb begin
        full = (count_q == FullCount);
        // out_valid is low when empty, so a same-cycle push never pops an empty FIFO.
        pop       = out_valid & out_ready;
        push_ok   = push & (~full | pop);
        dropped_d = dropped_q | (push & full & ~pop);

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dropped_q <= dropped_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr_q] <= push_rec;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_code   = out_valid ? mem[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_morse_char_assembler.sv
// Bench for morse_char_assembler: directed scenarios plus random pulse traffic, checked every
// cycle against a queue-based model of element lists and queued records.
module tb_morse_char_assembler;

    localparam int MAX_ELEMS = 5;
    localparam int DEPTH     = 4;
    localparam int CW        = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dot = 1'b0;
    logic          dash = 1'b0;
    logic          lg = 1'b0;
    logic          wg = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [7:0]    out_code;
    logic          out_valid;
    logic [CW-1:0] fifo_count;
    logic          dropped;

    morse_char_assembler #(
        .MAX_ELEMS(MAX_ELEMS),
        .DEPTH    (DEPTH),
        .CW       (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .dot       (dot),
        .dash      (dash),
        .lg        (lg),
        .wg        (wg),
        .flush     (flush),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fifo_count(fifo_count),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: elements of the open character (1 = dash), queued records, pending space, sticky drop.
    logic [7:0] mq[$];
    bit         el[$];
    bit         m_space;
    bit         m_dropped;

    function automatic logic [7:0] char_record();
        logic [4:0] pat;
        int n;
        n   = el.size();
        pat = '0;
        if (n > MAX_ELEMS) return 8'hE0;
        for (int i = 0; i < n; i++) pat[n-1-i] = el[i];
        return {3'(n), pat};
    endfunction

    task automatic model_clock(input bit d, input bit da, input bit l, input bit w, input bit f,
                               input bit r);
        bit         pop;
        bit         push;
        logic [7:0] rec;
        pop  = r && (mq.size() > 0);
        push = 1'b0;
        rec  = 8'h00;
        if (m_space) begin
            push    = 1'b1;
            m_space = 1'b0;
        end else if (w) begin
            push = 1'b1;
            if (el.size() > 0) begin
                rec     = char_record();
                m_space = 1'b1;
            end
            el.delete();
        end else if (l || f) begin
            if (el.size() > 0) begin
                push = 1'b1;
                rec  = char_record();
            end
            el.delete();
        end
        if (d || da) el.push_back(da);
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(rec);
            else m_dropped = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] exp_code;
        logic       exp_valid;
        exp_valid = (mq.size() > 0);
        exp_code  = exp_valid ? mq[0] : 8'h00;
        checks++;
        assert (out_valid === exp_valid) else begin
            failures++;
            $error("FAIL %s out_valid: got %b want %b", tag, out_valid, exp_valid);
        end
        checks++;
        assert (out_code === exp_code) else begin
            failures++;
            $error("FAIL %s out_code: got %h want %h", tag, out_code, exp_code);
        end
        checks++;
        assert (fifo_count === CW'(mq.size())) else begin
            failures++;
            $error("FAIL %s fifo_count: got %0d want %0d", tag, fifo_count, mq.size());
        end
        checks++;
        assert (dropped === m_dropped) else begin
            failures++;
            $error("FAIL %s dropped: got %b want %b", tag, dropped, m_dropped);
        end
    endtask

    task automatic check_const(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step(input bit d, input bit da, input bit l, input bit w, input bit f,
                        input bit r, input string tag);
        @(negedge clk);
        reset = 1'b0; dot = d; dash = da; lg = l; wg = w; flush = f; out_ready = r;
        @(posedge clk);
        model_clock(d, da, l, w, f, r);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, r, "idle");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; dot = 0; dash = 0; lg = 0; wg = 0; flush = 0; out_ready = 0;
        @(posedge clk);
        mq.delete();
        el.delete();
        m_space   = 1'b0;
        m_dropped = 1'b0;
        #1;
        check_outputs("reset");
    endtask

    initial begin
        do_reset();
        check_const("reset_code", out_code, 8'h00);

        // dot, dash, dash, lg
        step(1, 0, 0, 0, 0, 1, "t1_dot");  idle(1, 1);
        step(0, 1, 0, 0, 0, 1, "t1_dash"); idle(1, 1);
        step(0, 1, 0, 0, 0, 1, "t1_dash"); idle(1, 1);
        step(0, 0, 1, 0, 0, 1, "t1_lg");
        check_const("t1_code", out_code, 8'b011_00011);
        step(0, 0, 0, 0, 0, 1, "t1_after");
        check_const("t1_gone", {7'd0, out_valid}, 8'h00);

        // dash, dot, wg -> char then space; lone wg -> space only
        step(0, 1, 0, 0, 0, 1, "t2_dash");
        step(1, 0, 0, 0, 0, 1, "t2_dot");
        step(0, 0, 0, 1, 0, 1, "t2_wg");
        check_const("t2_char", out_code, 8'b010_00010);
        step(0, 0, 0, 0, 0, 1, "t2_space");
        check_const("t2_space_valid", {7'd0, out_valid}, 8'h01);
        idle(2, 1);
        step(0, 0, 0, 1, 0, 1, "t2_wg_alone");
        check_const("t2_lone_space", {out_code[6:0], out_valid}, 8'h01);
        idle(2, 1);

        // overflow then a normal character
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 1, "t3_dot");
        step(0, 0, 1, 0, 0, 1, "t3_lg");
        check_const("t3_err", out_code, 8'b111_00000);
        step(1, 0, 0, 0, 0, 1, "t3_dot2");
        step(0, 0, 1, 0, 0, 1, "t3_lg2");
        check_const("t3_next", out_code, 8'b001_00000);
        idle(1, 1);

        // fill past DEPTH with the consumer stalled, then drain
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0, 0, "t4_dot");
            step(0, 0, 1, 0, 0, 0, "t4_lg");
        end
        check_const("t4_count", 8'(fifo_count), 8'd4);
        check_const("t4_dropped", {7'd0, dropped}, 8'h01);
        for (int i = 0; i < 4; i++) begin
            check_const("t4_drain", out_code, 8'h20);
            step(0, 0, 0, 0, 0, 1, "t4_pop");
        end
        check_const("t4_empty", 8'(fifo_count), 8'd0);
        check_const("t4_sticky", {7'd0, dropped}, 8'h01);

        // full FIFO: push and pop in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0, 0, "t5_dot");
            step(0, 0, 1, 0, 0, 0, "t5_lg");
        end
        step(0, 1, 0, 0, 0, 0, "t5_dash");
        step(0, 0, 1, 0, 0, 1, "t5_lg_pop");
        check_const("t5_count", 8'(fifo_count), 8'd4);
        check_const("t5_nodrop", {7'd0, dropped}, 8'h00);
        idle(3, 1);
        check_const("t5_last", out_code, 8'b001_00001);
        idle(2, 1);

        // reset discards partial character
        step(1, 0, 0, 0, 0, 1, "t6_dot");
        step(0, 1, 0, 0, 0, 1, "t6_dash");
        do_reset();
        step(0, 0, 1, 0, 0, 1, "t6_lg");
        check_const("t6_none", {4'd0, fifo_count, out_valid}, 8'h00);
        step(0, 1, 0, 0, 0, 1, "t6_dash2");
        step(0, 0, 0, 0, 1, 1, "t6_flush");
        check_const("t6_code", out_code, 8'b001_00001);
        idle(2, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25,
                     $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 5,
                     $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 50, "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/morse_char_assembler.md
Name: morse_char_assembler

Overview:
Controller that sits downstream of the Morse element decoder and sequences its single-cycle dot/dash/letter-gap/word-gap pulses into complete character records. It accumulates up to MAX_ELEMS elements per character and closes the character on a gap. Finished records are queued in a small show-ahead FIFO and drained through a valid/ready handshake by the display or UART consumer.

Parameters:
MAX_ELEMS, 5, maximum dot/dash elements per character; fixed 5-bit pattern field, legal range 1..5
DEPTH, 4, FIFO depth in records; power of two, 2..16
CW, 3, width of fifo_count; must satisfy 2^CW > DEPTH

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
dot  input  1  single-cycle pulse, one dot element detected
dash  input  1  single-cycle pulse, one dash element detected
lg  input  1  single-cycle pulse, letter gap detected
wg  input  1  single-cycle pulse, word gap detected
flush  input  1  single-cycle pulse, close the current character as if lg arrived
out_code  output  8  head record {len[2:0], pattern[4:0]}
out_valid  output  1  FIFO non-empty, out_code valid
out_ready  input  1  consumer accepts the head record when out_valid & out_ready
fifo_count  output  CW  records currently queued
dropped  output  1  sticky flag, a record was lost because the FIFO was full; cleared only by reset

Behaviour:
- Reset (synchronous, active-high): state=COLLECT, len=0, pattern=0, FIFO empty, out_valid=0, out_code=0, fifo_count=0, dropped=0. Reset mid-operation discards the partial character and all queued records.
- Element capture, COLLECT state:
  - dot or dash: pattern <= {pattern[3:0], dash}, so the newest element is in bit 0 and the first element is at bit len-1.
  - len increments, saturating at 7.
  - len reaching MAX_ELEMS+1 marks the character as an overflow.
  - Bits of pattern above len-1 are 0.
- Record encoding:
  - len 1..5: normal character.
  - len=0, pattern=0: space record.
  - len=7, pattern=0: error record, emitted for an overflowed character.
- Character close, on lg or flush:
  - If len>0, push the record in the same cycle, then clear len and pattern.
  - If len=0, nothing is pushed.
- Word gap, on wg:
  - If len>0, push the character record this cycle and go to PUSH_SPACE.
  - PUSH_SPACE pushes the space record the next cycle, then returns to COLLECT.
  - If len=0, push only the space record, directly from COLLECT.
- Elements arriving while in PUSH_SPACE: capture into the now-cleared accumulator as the first element of the next character. lg, wg and flush arriving in PUSH_SPACE are ignored.
- Simultaneous pulses, priority wg > lg = flush > dot/dash.
  - Element plus gap in the same cycle: close the character first, then the element starts the new character (len=1).
  - dot and dash together: treated as dash.
- FIFO:
  - Show-ahead. A record pushed in cycle N appears on out_code with out_valid=1 in cycle N+1.
  - Pop happens when out_valid & out_ready; the next record appears the following cycle.
  - Push while full is accepted only if a pop occurs in the same cycle. Otherwise the record is discarded and dropped <= 1.
  - Simultaneous push and pop on an empty FIFO: no pop occurs; the record is queued normally.
  - Read and write pointers wrap modulo DEPTH. fifo_count = writes minus reads, range 0..DEPTH.
  - out_code holds its value while out_valid=1 and out_ready=0.
  - out_code is undefined-free: it reads 0 when empty.
- States: COLLECT and PUSH_SPACE only. PUSH_SPACE lasts exactly one cycle.

Test Plan:
- dot, dash, dash (separated by idle cycles), then lg, out_ready=1 → one record 8'b011_00011, out_valid high exactly one cycle, starting the cycle after lg.
- dash, dot, then wg, out_ready=1 → records 8'b010_00010 then 8'b000_00000 on consecutive cycles; wg with len=0 → single 8'h00.
- Six dots then lg → one record 8'b111_00000; a following dot, lg → 8'b001_00000.
- out_ready=0; five single-dot characters closed by lg (DEPTH=4) → fifo_count=4, dropped=1. Then drain → codes 8'h20 ×4 in order, fifo_count returns to 0, dropped stays 1.
- FIFO full with pop and push in the same cycle → fifo_count stays 4, no drop; the new record appears last in order.
- dot, dash, then reset asserted for one cycle, then lg → no record, out_valid=0, fifo_count=0; then dash, flush → 8'b001_00001.
